// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM state encoding and helpers.
package boot_pkg;

  typedef enum logic [2:0] {IDLE, LEN, LOAD, CHECK, RUN, ERR} bootstate_t;

  localparam int BYTE_W = 8;

  // The loader owns the host stream in these states.
  function automatic logic loading(input bootstate_t s);
    return (s == LEN) || (s == LOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/boot_memmux.sv
// Memory port select: the cpu owns the memory in RUN, the loader everywhere else.
module boot_memmux #(
  parameter int WIDTH = 8
) (
  input  logic             cpu_sel,
  input  logic             ld_write,
  input  logic [WIDTH-1:0] ld_adr,
  input  logic [WIDTH-1:0] ld_wdata,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata
);

  // The loader never reads, so mem_read is gated off outside RUN.
  assign mem_read  = cpu_sel & cpu_memread;
  assign mem_write = cpu_sel ? cpu_memwrite  : ld_write;
  assign mem_adr   = cpu_sel ? cpu_adr       : ld_adr;
  assign mem_wdata = cpu_sel ? cpu_writedata : ld_wdata;

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed image into memory while holding mips in reset, then runs it.
// Optional trailing checksum byte and ERR state when BOOT_CHECKSUM_EN is defined.
module boot_loader
  import boot_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             cpu_reset,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             busy,
  output logic             err
);

  bootstate_t       state;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] din_w;
  logic             xfer, len_xfer, load_xfer, last;

  assign in_ready  = loading(state);
  assign busy      = loading(state);
  assign din_w     = WIDTH'(in_data);
  // A byte accepted together with start belongs to the discarded image.
  assign xfer      = in_valid & in_ready & ~start;
  assign len_xfer  = xfer && (state == LEN);
  assign load_xfer = xfer && (state == LOAD);
  assign last      = (remaining == WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                addr <= '0;
    else if (start || len_xfer)  addr <= '0;
    else if (load_xfer)          addr <= addr + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        remaining <= '0;
    else if (len_xfer)   remaining <= din_w;
    else if (load_xfer)  remaining <= remaining - WIDTH'(1);
  end

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] chk_total;

  assign chk_total = sum + in_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            sum <= '0;
    else if (state == LEN)   sum <= '0;
    else if (load_xfer)      sum <= sum + in_data;
  end
`else
  assign err = 1'b0;
`endif

  // cpu_reset is updated on the same edge that enters or leaves RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cpu_reset <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      err       <= 1'b0;
`endif
    end else if (start) begin
      state     <= LEN;
      cpu_reset <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        LEN: if (xfer) begin
          if (in_data != 8'h00) state <= LOAD;
`ifdef BOOT_CHECKSUM_EN
          else                  state <= CHECK;
`else
          else begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end
`endif
        end
        LOAD: if (xfer && last) begin
`ifdef BOOT_CHECKSUM_EN
          state <= CHECK;
`else
          state     <= RUN;
          cpu_reset <= 1'b0;
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        CHECK: if (xfer) begin
          if (chk_total == 8'h00) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
        ERR: ;
`endif
        IDLE, RUN: ;
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  boot_memmux #(.WIDTH(WIDTH)) u_memmux (
    .cpu_sel       (state == RUN),
    .ld_write      (load_xfer),
    .ld_adr        (addr),
    .ld_wdata      (din_w),
    .cpu_memread   (cpu_memread),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_adr       (mem_adr),
    .mem_wdata     (mem_wdata)
  );

endmodule
